alu_secuenciador: RTL

//  Upstream command stage for the 8-bit ALU (sel[1:0], A[7:0], B[7:0] -> C[8:0]).
//  - Buffers operation commands in a small FIFO.
//  - Drives each command onto the ALU inputs, holds the inputs stable for a settle window,

---
 rtl/alu_secuenciador_if.sv | 33 +++
 rtl/alu_secuenciador.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_secuenciador_if.sv
// Command, ALU and result bundle for the ALU command sequencer.
// The slave side is the sequencer; the master side is its environment.
interface alu_secuenciador_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_sel;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic [1:0]       alu_sel;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [8:0]       alu_c;
    logic             res_valid;
    logic             res_ready;
    logic [8:0]       res_data;
    logic [1:0]       res_sel;
    logic [CNT_W-1:0] op_count;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, alu_c, res_ready,
        output cmd_ready, alu_sel, alu_a, alu_b,
        output res_valid, res_data, res_sel, op_count, busy
    );

    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, alu_c, res_ready,
        input  cmd_ready, alu_sel, alu_a, alu_b,
        input  res_valid, res_data, res_sel, op_count, busy
    );
endinterface

// File: rtl/alu_secuenciador.sv
// Command stage for the 8-bit ALU: FIFO-buffered commands, ALU drive
// with a settle window, registered result on a valid/ready port.
module alu_secuenciador #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst_n,
    alu_secuenciador_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    cmd_t             mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    cmd_t             head;

    state_t           state_q;
    logic [SW-1:0]    set_q;
    logic [1:0]       sel_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [8:0]       rdata_q;
    logic [1:0]       rsel_q;
    logic             rvalid_q;
    logic [CNT_W-1:0] opcnt_q;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_q];
    assign push  = bus.cmd_valid && bus.cmd_ready;
    assign pop   = !empty &&
                   ((state_q == IDLE) || (state_q == HOLD && bus.res_ready));

    assign bus.cmd_ready = rst_n && !full;
    assign bus.alu_sel   = sel_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.res_valid = rvalid_q;
    assign bus.res_data  = rdata_q;
    assign bus.res_sel   = rsel_q;
    assign bus.op_count  = opcnt_q;
    assign bus.busy      = (state_q != IDLE) || !empty;

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_d = cnt_q - 1'b1;
    end

    // Command FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= '{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop)
                rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Sequencer: load ALU inputs, wait the settle window, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            set_q    <= '0;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rdata_q  <= '0;
            rsel_q   <= '0;
            rvalid_q <= 1'b0;
            opcnt_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        sel_q   <= head.sel;
                        a_q     <= head.a;
                        b_q     <= head.b;
                        set_q   <= '0;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    set_q <= set_q + 1'b1;
                    if (set_q == SW'(SETTLE - 1)) begin
                        rdata_q  <= bus.alu_c;
                        rsel_q   <= sel_q;
                        rvalid_q <= 1'b1;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        opcnt_q  <= opcnt_q + 1'b1;
                        rvalid_q <= 1'b0;
                        if (pop) begin
                            sel_q   <= head.sel;
                            a_q     <= head.a;
                            b_q     <= head.b;
                            set_q   <= '0;
                            state_q <= DRIVE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
